// File: rtl/div_n_reg_pkg.sv
// div_n_reg_pkg
// Shared definitions for the divisible-by-N register slave.
//  - word addresses of every mapped register
//  - bit positions inside CTRL and STATUS
//  - packed STATUS layout (bit 0 bad_cfg, bit 1 cnt_sat)
// Also supplies default register-bus widths when the build does not set
// REG_ADDR_SZ / REG_DATA_SZ.
// Optional feature macro used elsewhere in this slice: REG_BUS_ERR_EN.

`ifndef REG_ADDR_SZ
`define REG_ADDR_SZ 8
`endif
`ifndef REG_DATA_SZ
`define REG_DATA_SZ 32
`endif

package div_n_reg_pkg;

  localparam int CTRL_ADDR      = 0;
  localparam int DIVISOR_ADDR   = 1;
  localparam int STATUS_ADDR    = 2;
  localparam int BIT_CNT_ADDR   = 3;
  localparam int MATCH_CNT_ADDR = 4;
  localparam int SCRATCH_ADDR   = 5;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;

  localparam int STATUS_BAD_BIT = 0;
  localparam int STATUS_SAT_BIT = 1;

  // Field order matters: the struct is read back directly as STATUS[1:0]
  typedef struct packed {
    logic cnt_sat;
    logic bad_cfg;
  } status_t;

endpackage

// File: rtl/div_n_sat_cnt.sv
// div_n_sat_cnt
// Saturating event counter used for BIT_CNT and MATCH_CNT.
// Ports:
//  clk  in   1       clock
//  rst  in   1       synchronous reset, active-high
//  inc  in   1       count one event (already gated by the caller)
//  clr  in   1       clear to zero; wins over inc, so that event is dropped
//  cnt  out  CNT_SZ  current count, holds at all-ones once reached
//  sat  out  1       single-cycle flag: this edge moves the count onto all-ones

module div_n_sat_cnt #(
  parameter int CNT_SZ = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [CNT_SZ-1:0] cnt,
  output logic              sat
);

  localparam logic [CNT_SZ-1:0] CNT_MAX = '1;

  logic [CNT_SZ-1:0] cnt_q;
  logic [CNT_SZ-1:0] cnt_d;

  // Next count: clear first, otherwise step unless already pinned at all-ones.
  // sat fires only on the step that lands on all-ones, so a sticky status
  // bit fed from it is set exactly once per saturation.
  always_comb begin
    cnt_d = cnt_q;
    sat   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_SZ'(1);
      sat   = (cnt_d == CNT_MAX);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/div_n_reg_slave.sv
// div_n_reg_slave
// Register-bus responder for the divisible-by-N IP. Holds the core
// configuration (enable, divisor), a scratch register, sticky status and two
// saturating event counters fed by the core.
// Ports:
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active-high
//  reg_rd_en      in   1        read strobe
//  reg_wr_en      in   1        write strobe
//  reg_addr       in   ADDR_SZ  word address
//  reg_wr_data    in   DATA_SZ  write data
//  reg_rd_data    out  DATA_SZ  read data, registered, one cycle after reg_rd_en
//  cfg_en         out  1        CTRL.enable to core
//  cfg_divisor    out  N_SZ     DIVISOR to core
//  evt_bit_vld    in   1        core consumed one input bit
//  evt_divisible  in   1        core flagged running value divisible
//  reg_err        out  1        only with REG_BUS_ERR_EN: pulse aligned with
//                               reg_rd_data for unmapped access, write to a
//                               read-only counter, or rd+wr in one cycle
// Configuration macro: REG_BUS_ERR_EN (adds reg_err; register behaviour unchanged).

`ifndef REG_ADDR_SZ
`define REG_ADDR_SZ 8
`endif
`ifndef REG_DATA_SZ
`define REG_DATA_SZ 32
`endif

module div_n_reg_slave
  import div_n_reg_pkg::*;
#(
  parameter int ADDR_SZ = `REG_ADDR_SZ,
  parameter int DATA_SZ = `REG_DATA_SZ,
  parameter int N_SZ    = 8,
  parameter int CNT_SZ  = 16,
  parameter int DIV_RST = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_rd_en,
  input  logic               reg_wr_en,
  input  logic [ADDR_SZ-1:0] reg_addr,
  input  logic [DATA_SZ-1:0] reg_wr_data,
  output logic [DATA_SZ-1:0] reg_rd_data,
  output logic               cfg_en,
  output logic [N_SZ-1:0]    cfg_divisor,
  input  logic               evt_bit_vld,
`ifdef REG_BUS_ERR_EN
  input  logic               evt_divisible,
  output logic               reg_err
`else
  input  logic               evt_divisible
`endif
);

  logic               en_q, en_d;
  logic [N_SZ-1:0]    div_q, div_d;
  status_t            status_q, status_d;
  logic [DATA_SZ-1:0] scratch_q, scratch_d;
  logic [DATA_SZ-1:0] rd_data_q, rd_data_d;

  logic wr_ctrl, wr_div, wr_status, wr_scratch;
  logic soft_clr;
  logic bit_inc, match_inc;
  logic bit_sat, match_sat;
  logic [CNT_SZ-1:0] bit_cnt, match_cnt;

  // Address decode for writes. soft_clr is a pure strobe: it is never stored,
  // which is why CTRL bit 1 always reads back as 0.
  always_comb begin
    wr_ctrl    = reg_wr_en && (reg_addr == ADDR_SZ'(CTRL_ADDR));
    wr_div     = reg_wr_en && (reg_addr == ADDR_SZ'(DIVISOR_ADDR));
    wr_status  = reg_wr_en && (reg_addr == ADDR_SZ'(STATUS_ADDR));
    wr_scratch = reg_wr_en && (reg_addr == ADDR_SZ'(SCRATCH_ADDR));
    soft_clr   = wr_ctrl && reg_wr_data[CTRL_CLR_BIT];
  end

  // Events count with the enable already in force; a write to CTRL only
  // affects counting from the following cycle.
  assign bit_inc   = evt_bit_vld   && en_q;
  assign match_inc = evt_divisible && en_q;

  div_n_sat_cnt #(.CNT_SZ(CNT_SZ)) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bit_inc),
    .clr (soft_clr),
    .cnt (bit_cnt),
    .sat (bit_sat)
  );

  div_n_sat_cnt #(.CNT_SZ(CNT_SZ)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_inc),
    .clr (soft_clr),
    .cnt (match_cnt),
    .sat (match_sat)
  );

  // Configuration and scratch updates. A zero divisor would stall the core,
  // so such a write keeps the old value and is reported via bad_cfg instead.
  always_comb begin
    en_d      = en_q;
    div_d     = div_q;
    scratch_d = scratch_q;
    if (wr_ctrl) begin
      en_d = reg_wr_data[CTRL_EN_BIT];
    end
    if (wr_div && (reg_wr_data[N_SZ-1:0] != '0)) begin
      div_d = reg_wr_data[N_SZ-1:0];
    end
    if (wr_scratch) begin
      scratch_d = reg_wr_data;
    end
  end

  // Sticky status. Clears are applied first and set conditions last, so a
  // new event arriving with a write-1-to-clear keeps the bit set.
  always_comb begin
    status_d = status_q;
    if (wr_status) begin
      if (reg_wr_data[STATUS_BAD_BIT]) status_d.bad_cfg = 1'b0;
      if (reg_wr_data[STATUS_SAT_BIT]) status_d.cnt_sat = 1'b0;
    end
    if (soft_clr) begin
      status_d.cnt_sat = 1'b0;
    end
    if (wr_div && (reg_wr_data[N_SZ-1:0] == '0)) begin
      status_d.bad_cfg = 1'b1;
    end
    if (bit_sat || match_sat) begin
      status_d.cnt_sat = 1'b1;
    end
  end

  // Read mux works on the current register values, so a read colliding with
  // a write or a counter increment returns the pre-update contents. With no
  // read strobe the previous read data is held.
  always_comb begin
    rd_data_d = rd_data_q;
    if (reg_rd_en) begin
      case (reg_addr)
        ADDR_SZ'(CTRL_ADDR):      rd_data_d = DATA_SZ'(en_q);
        ADDR_SZ'(DIVISOR_ADDR):   rd_data_d = DATA_SZ'(div_q);
        ADDR_SZ'(STATUS_ADDR):    rd_data_d = DATA_SZ'(status_q);
        ADDR_SZ'(BIT_CNT_ADDR):   rd_data_d = DATA_SZ'(bit_cnt);
        ADDR_SZ'(MATCH_CNT_ADDR): rd_data_d = DATA_SZ'(match_cnt);
        ADDR_SZ'(SCRATCH_ADDR):   rd_data_d = scratch_q;
        default:                  rd_data_d = '0;
      endcase
    end
  end

  // Register bank; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      div_q     <= N_SZ'(DIV_RST);
      status_q  <= '0;
      scratch_q <= '0;
      rd_data_q <= '0;
    end else begin
      en_q      <= en_d;
      div_q     <= div_d;
      status_q  <= status_d;
      scratch_q <= scratch_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign reg_rd_data = rd_data_q;
  assign cfg_en      = en_q;
  assign cfg_divisor = div_q;

`ifdef REG_BUS_ERR_EN
  logic err_q, err_d;

  // Bus error: unmapped address, write to a read-only counter, or a
  // simultaneous read and write. Registered so it lines up with reg_rd_data.
  always_comb begin
    err_d = 1'b0;
    if ((reg_rd_en || reg_wr_en) && (reg_addr > ADDR_SZ'(SCRATCH_ADDR))) begin
      err_d = 1'b1;
    end
    if (reg_wr_en && ((reg_addr == ADDR_SZ'(BIT_CNT_ADDR)) ||
                      (reg_addr == ADDR_SZ'(MATCH_CNT_ADDR)))) begin
      err_d = 1'b1;
    end
    if (reg_rd_en && reg_wr_en) begin
      err_d = 1'b1;
    end
  end

  // Error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign reg_err = err_q;
`endif

endmodule

// File: tb/tb_div_n_reg_slave.sv
// tb_div_n_reg_slave
// Self-checking bench for div_n_reg_slave, built with 4-bit counters so that
// saturation is reachable quickly. A transaction-level model of the register
// map tracks expected contents; directed scenarios check fixed values and a
// randomized phase checks every cycle against the model.

module tb_div_n_reg_slave;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int NW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          reg_rd_en;
  logic          reg_wr_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wr_data;
  logic [DW-1:0] reg_rd_data;
  logic          cfg_en;
  logic [NW-1:0] cfg_divisor;
  logic          evt_bit_vld;
  logic          evt_divisible;
`ifdef REG_BUS_ERR_EN
  logic          reg_err;
`endif

  int n_cmp;
  int n_fail;

  // Reference model state
  bit          m_en;
  int          m_div;
  bit          m_bad;
  bit          m_sat;
  int          m_bit;
  int          m_match;
  logic [31:0] m_scratch;
  logic [31:0] exp_rd;
  bit          exp_err;

  div_n_reg_slave #(
    .ADDR_SZ (AW),
    .DATA_SZ (DW),
    .N_SZ    (NW),
    .CNT_SZ  (CW),
    .DIV_RST (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .reg_rd_en     (reg_rd_en),
    .reg_wr_en     (reg_wr_en),
    .reg_addr      (reg_addr),
    .reg_wr_data   (reg_wr_data),
    .reg_rd_data   (reg_rd_data),
    .cfg_en        (cfg_en),
    .cfg_divisor   (cfg_divisor),
    .evt_bit_vld   (evt_bit_vld),
`ifdef REG_BUS_ERR_EN
    .evt_divisible (evt_divisible),
    .reg_err       (reg_err)
`else
    .evt_divisible (evt_divisible)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register contents as the map describes them, before this cycle's updates
  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'd0:    return {31'b0, m_en};
      8'd1:    return 32'(m_div);
      8'd2:    return {30'b0, m_sat, m_bad};
      8'd3:    return 32'(m_bit);
      8'd4:    return 32'(m_match);
      8'd5:    return m_scratch;
      default: return 32'b0;
    endcase
  endfunction

  // Drive one bus cycle, advance the model at the clock edge, return #1 later
  task automatic cycle(input bit r, input bit rd, input bit wr, input logic [7:0] a,
                       input logic [31:0] wd, input bit bv, input bit dv);
    bit clr, sat_ev, bad_ev;
    rst = r; reg_rd_en = rd; reg_wr_en = wr; reg_addr = a; reg_wr_data = wd;
    evt_bit_vld = bv; evt_divisible = dv;
    @(posedge clk);
    if (r) begin
      m_en = 0; m_div = 3; m_bad = 0; m_sat = 0; m_bit = 0; m_match = 0;
      m_scratch = 0; exp_rd = 0; exp_err = 0;
    end else begin
      if (rd) exp_rd = model_read(a);
      exp_err = ((rd || wr) && a > 5) || (wr && (a == 3 || a == 4)) || (rd && wr);
      clr = wr && a == 0 && wd[1];
      sat_ev = 0;
      bad_ev = 0;
      if (clr) begin
        m_bit = 0; m_match = 0; m_sat = 0;
      end else if (m_en) begin
        if (bv && m_bit < CMAX) begin
          m_bit = m_bit + 1;
          if (m_bit == CMAX) sat_ev = 1;
        end
        if (dv && m_match < CMAX) begin
          m_match = m_match + 1;
          if (m_match == CMAX) sat_ev = 1;
        end
      end
      if (wr) begin
        case (a)
          8'd0: m_en = wd[0];
          8'd1: if (wd[7:0] == 8'd0) bad_ev = 1; else m_div = int'(wd[7:0]);
          8'd2: begin
            if (wd[0]) m_bad = 0;
            if (wd[1]) m_sat = 0;
          end
          8'd5: m_scratch = wd;
          default: ;
        endcase
      end
      if (bad_ev) m_bad = 1;
      if (sat_ev) m_sat = 1;
    end
    #1;
    rst = 0; reg_rd_en = 0; reg_wr_en = 0; evt_bit_vld = 0; evt_divisible = 0;
  endtask

  task automatic test_reset();
    logic [31:0] want [0:5];
    want[0] = 0; want[1] = 3; want[2] = 0; want[3] = 0; want[4] = 0; want[5] = 0;
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (cfg_en !== 1'b0 || cfg_divisor !== 8'd3) begin
      n_fail++;
      $display("[TB] FAIL reset_cfg got en=%0b div=%0d want en=0 div=3", cfg_en, cfg_divisor);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 0, 8'(i), 0, 0, 0);
      n_cmp++;
      if (reg_rd_data !== want[i] || reg_rd_data !== exp_rd) begin
        n_fail++;
        $display("[TB] FAIL reset_read addr=%0d got=%0h want=%0h", i, reg_rd_data, want[i]);
      end
    end
    cycle(0, 1, 0, 8'h7, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL unmapped_read got=%0h want=0", reg_rd_data);
    end
`ifdef REG_BUS_ERR_EN
    n_cmp++;
    if (reg_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL unmapped_err got=%0b want=1", reg_err);
    end
`endif
  endtask

  task automatic test_divisor_zero();
    cycle(0, 0, 1, 8'h1, 32'h0, 0, 0);
    cycle(0, 1, 0, 8'h1, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd3 || cfg_divisor !== 8'd3) begin
      n_fail++;
      $display("[TB] FAIL div_zero_kept got=%0d/%0d want=3", reg_rd_data, cfg_divisor);
    end
    cycle(0, 1, 0, 8'h2, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'h1) begin
      n_fail++;
      $display("[TB] FAIL bad_cfg_set got=%0h want=1", reg_rd_data);
    end
    cycle(0, 0, 1, 8'h2, 32'h1, 0, 0);
    cycle(0, 1, 0, 8'h2, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL bad_cfg_w1c got=%0h want=0", reg_rd_data);
    end
    cycle(0, 0, 1, 8'h1, 32'h9, 0, 0);
    n_cmp++;
    if (cfg_divisor !== 8'd9) begin
      n_fail++;
      $display("[TB] FAIL div_write got=%0d want=9", cfg_divisor);
    end
  endtask

  task automatic test_counters();
    cycle(0, 0, 1, 8'h0, 32'h1, 0, 0);
    n_cmp++;
    if (cfg_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ctrl_enable got=%0b want=1", cfg_en);
    end
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 1, i < 4);
    cycle(0, 1, 0, 8'h3, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd10) begin
      n_fail++;
      $display("[TB] FAIL bit_cnt got=%0d want=10", reg_rd_data);
    end
    cycle(0, 1, 0, 8'h4, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd4) begin
      n_fail++;
      $display("[TB] FAIL match_cnt got=%0d want=4", reg_rd_data);
    end
    cycle(0, 0, 1, 8'h0, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, 1);
    cycle(0, 1, 0, 8'h3, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd10) begin
      n_fail++;
      $display("[TB] FAIL bit_cnt_disabled got=%0d want=10", reg_rd_data);
    end
    cycle(0, 1, 0, 8'h4, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd4) begin
      n_fail++;
      $display("[TB] FAIL match_cnt_disabled got=%0d want=4", reg_rd_data);
    end
  endtask

  task automatic test_saturation();
    cycle(0, 0, 1, 8'h0, 32'h1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 8'h3, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd15) begin
      n_fail++;
      $display("[TB] FAIL bit_cnt_sat got=%0d want=15", reg_rd_data);
    end
    cycle(0, 1, 0, 8'h2, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'h2) begin
      n_fail++;
      $display("[TB] FAIL cnt_sat_set got=%0h want=2", reg_rd_data);
    end
    // soft clear with an event in the same cycle: the event is dropped
    cycle(0, 0, 1, 8'h0, 32'h3, 1, 1);
    cycle(0, 1, 0, 8'h3, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL soft_clr_bit got=%0d want=0", reg_rd_data);
    end
    cycle(0, 1, 0, 8'h4, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL soft_clr_match got=%0d want=0", reg_rd_data);
    end
    cycle(0, 1, 0, 8'h2, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL soft_clr_status got=%0h want=0", reg_rd_data);
    end
    cycle(0, 1, 0, 8'h0, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'h1) begin
      n_fail++;
      $display("[TB] FAIL ctrl_readback got=%0h want=1", reg_rd_data);
    end
    // read collides with an increment: pre-increment value returned
    cycle(0, 1, 0, 8'h3, 0, 1, 0);
    n_cmp++;
    if (reg_rd_data !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL rd_vs_inc got=%0d want=0", reg_rd_data);
    end
    cycle(0, 0, 1, 8'h0, 32'h0, 0, 0);
  endtask

  task automatic test_back_to_back();
    cycle(0, 1, 1, 8'h5, 32'hA5, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL rdwr_prewrite got=%0h want=0", reg_rd_data);
    end
`ifdef REG_BUS_ERR_EN
    n_cmp++;
    if (reg_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rdwr_err got=%0b want=1", reg_err);
    end
`endif
    cycle(0, 0, 0, 8'h0, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL rd_hold got=%0h want=0", reg_rd_data);
    end
    cycle(0, 1, 0, 8'h5, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'hA5) begin
      n_fail++;
      $display("[TB] FAIL scratch_read got=%0h want=a5", reg_rd_data);
    end
  endtask

  task automatic test_reset_mid_write();
    cycle(0, 0, 1, 8'h0, 32'h1, 0, 0);
    cycle(0, 0, 1, 8'h1, 32'h7, 0, 0);
    cycle(1, 0, 1, 8'h5, 32'h55, 0, 0);
    n_cmp++;
    if (cfg_en !== 1'b0 || cfg_divisor !== 8'd3 || reg_rd_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_cfg got en=%0b div=%0d rd=%0h want en=0 div=3 rd=0",
               cfg_en, cfg_divisor, reg_rd_data);
    end
    cycle(0, 1, 0, 8'h5, 0, 0, 0);
    n_cmp++;
    if (reg_rd_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_scratch got=%0h want=0", reg_rd_data);
    end
  endtask

  task automatic test_random();
    bit rd, wr, r, bv, dv;
    logic [7:0] a;
    logic [31:0] wd;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      rd = $urandom_range(0, 1) == 1;
      wr = ($urandom_range(0, 2) == 0);
      a  = 8'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 8'h1 && $urandom_range(0, 3) == 0) wd = 0;
      if (a == 8'h0 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
      if (a == 8'h0 && $urandom_range(0, 2) != 0) wd[0] = 1'b1;
      bv = $urandom_range(0, 3) != 0;
      dv = $urandom_range(0, 2) == 0;
      cycle(r, rd, wr, a, wd, bv, dv);
      n_cmp++;
      if (reg_rd_data !== exp_rd || cfg_en !== m_en || cfg_divisor !== 8'(m_div)) begin
        n_fail++;
        $display("[TB] FAIL random cyc=%0d rd=%0h/%0h en=%0b/%0b div=%0d/%0d (got/want)",
                 i, reg_rd_data, exp_rd, cfg_en, m_en, cfg_divisor, m_div);
      end
`ifdef REG_BUS_ERR_EN
      n_cmp++;
      if (reg_err !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL random_err cyc=%0d got=%0b want=%0b", i, reg_err, exp_err);
      end
`endif
    end
    // Sweep every register once more against the model
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 8'(i), 0, 0, 0);
      n_cmp++;
      if (reg_rd_data !== exp_rd) begin
        n_fail++;
        $display("[TB] FAIL final_read addr=%0d got=%0h want=%0h", i, reg_rd_data, exp_rd);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1; reg_rd_en = 0; reg_wr_en = 0; reg_addr = 0; reg_wr_data = 0;
    evt_bit_vld = 0; evt_divisible = 0;
    exp_rd = 0; exp_err = 0;
    test_reset();
    test_divisor_zero();
    test_counters();
    test_saturation();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
